systolic_array_param: RTL and testbench

Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B for an N×K by K×N operand pair, with K set at run time. It is the successor to the fixed 4×4 array. It adds:
- configurable size and widths;
- internal input skewing;
- a valid/ready load handshake with bubble tolerance;
- a start/busy/done control FSM;
- row-serial result readout with backpressure.

It sits between the operand block buffers and the result writeback path.

---
 rtl/systolic_array_param.sv | 243 ++++++++++++++++++++++++
 tb/tb_systolic_array_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_param.sv
// Parametrised N x N output-stationary systolic multiplier computing C = A*B with a run-time
// inner dimension, internal operand skewing, valid/ready operand load and row-serial readout.
module systolic_array_param #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 40,
    parameter int KW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_col,
    input  logic [N*DW-1:0] b_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*AW-1:0] out_row,
    output logic            out_last,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    localparam int RW  = $clog2(N);
    localparam int DCW = $clog2(2 * N);

    state_t          state;
    logic [KW-1:0]   k_reg;
    logic [KW-1:0]   beat_cnt;
    logic [DCW-1:0]  drain_cnt;
    logic [RW-1:0]   row_ptr;

    logic            beat;
    logic            clear;

    logic signed [DW-1:0] row_a [N];
    logic                 row_av [N];
    logic signed [DW-1:0] col_b [N];
    logic                 col_bv [N];

    logic signed [DW-1:0] pe_a_q [N][N];
    logic                 pe_av_q [N][N];
    logic signed [DW-1:0] pe_b_q [N][N];
    logic                 pe_bv_q [N][N];
    logic signed [AW-1:0] acc_q [N][N];

    logic [RW-1:0]   row_sel;
    logic [N*AW-1:0] row_sel_data;

    assign beat  = in_valid & in_ready;
    assign clear = (state == IDLE) & start;

    function automatic logic signed [AW-1:0] mac_term(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = (2*DW)'(a) * (2*DW)'(b);
        return AW'(p);
    endfunction

    // Row n of A and column n of B are delayed by n cycles so operand pairs meet at each PE.
    for (genvar n = 0; n < N; n++) begin : g_skew
        if (n == 0) begin : g_direct
            assign row_a[n]  = a_col[n*DW +: DW];
            assign row_av[n] = beat;
            assign col_b[n]  = b_row[n*DW +: DW];
            assign col_bv[n] = beat;
        end else begin : g_delay
            logic signed [DW-1:0] sk_a [n];
            logic                 sk_av [n];
            logic signed [DW-1:0] sk_b [n];
            logic                 sk_bv [n];

            always_ff @(posedge clk or posedge rst) begin
                // NOTE: storage arrays get an explicit reset loop; an abort must not leave stale
                // operands behind, and the loop keeps every element on the same reset path.
                if (rst) begin
                    for (int s = 0; s < n; s++) begin
                        sk_a[s]  <= '0;
                        sk_av[s] <= 1'b0;
                        sk_b[s]  <= '0;
                        sk_bv[s] <= 1'b0;
                    end
                end else if (clear) begin
                    for (int s = 0; s < n; s++) begin
                        sk_av[s] <= 1'b0;
                        sk_bv[s] <= 1'b0;
                    end
                end else begin
                    sk_a[0]  <= a_col[n*DW +: DW];
                    sk_av[0] <= beat;
                    sk_b[0]  <= b_row[n*DW +: DW];
                    sk_bv[0] <= beat;
                    for (int s = 1; s < n; s++) begin
                        sk_a[s]  <= sk_a[s-1];
                        sk_av[s] <= sk_av[s-1];
                        sk_b[s]  <= sk_b[s-1];
                        sk_bv[s] <= sk_bv[s-1];
                    end
                end
            end

            assign row_a[n]  = sk_a[n-1];
            assign row_av[n] = sk_av[n-1];
            assign col_b[n]  = sk_b[n-1];
            assign col_bv[n] = sk_bv[n-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pe_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic signed [DW-1:0] a_in, b_in, a_q, b_q;
            logic                 av_in, bv_in, av_q, bv_q;
            logic signed [AW-1:0] acc;

            if (j == 0) begin : g_a_edge
                assign a_in  = row_a[i];
                assign av_in = row_av[i];
            end else begin : g_a_west
                assign a_in  = pe_a_q[i][j-1];
                assign av_in = pe_av_q[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in  = col_b[j];
                assign bv_in = col_bv[j];
            end else begin : g_b_north
                assign b_in  = pe_b_q[i-1][j];
                assign bv_in = pe_bv_q[i-1][j];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    av_q <= 1'b0;
                    b_q  <= '0;
                    bv_q <= 1'b0;
                    acc  <= '0;
                end else if (clear) begin
                    av_q <= 1'b0;
                    bv_q <= 1'b0;
                    acc  <= '0;
                end else begin
                    a_q  <= a_in;
                    av_q <= av_in;
                    b_q  <= b_in;
                    bv_q <= bv_in;
                    if (av_q && bv_q)
                        acc <= acc + mac_term(a_q, b_q);
                end
            end

            assign pe_a_q[i][j]  = a_q;
            assign pe_av_q[i][j] = av_q;
            assign pe_b_q[i][j]  = b_q;
            assign pe_bv_q[i][j] = bv_q;
            assign acc_q[i][j]   = acc;
        end
    end

    // Row loaded into the output register: row 0 when leaving DRAIN, the next row on a handshake.
    always_comb begin
        row_sel      = (state == OUT) ? row_ptr + RW'(1) : '0;
        row_sel_data = '0;
        for (int j = 0; j < N; j++)
            row_sel_data[j*AW +: AW] = acc_q[row_sel][j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            row_ptr   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg     <= k_len;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                        row_ptr   <= '0;
                        busy      <= 1'b1;
                        if (k_len == '0) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_row   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == k_reg - KW'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(2 * N - 1)) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_row   <= row_sel_data;
                        out_last  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (row_ptr == RW'(N - 1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_row   <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            row_ptr  <= row_ptr + RW'(1);
                            out_row  <= row_sel_data;
                            out_last <= (row_ptr == RW'(N - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_array_param.sv
// Directed bench for systolic_array_param: a 40-bit and a 32-bit accumulator instance share
// one stimulus stream and are checked against hand-computed results.
module tb_systolic_array_param;
    localparam int N  = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        k_len;
    logic              in_valid;
    logic [N*DW-1:0]   a_col;
    logic [N*DW-1:0]   b_row;
    logic              out_ready;

    logic              in_ready, out_valid, out_last, busy, done;
    logic [N*40-1:0]   out_row;
    logic              in_ready32, out_valid32, out_last32, busy32, done32;
    logic [N*32-1:0]   out_row32;

    longint a_m [N][8];
    longint b_m [8][N];
    longint c_exp [N][N];

    int checks = 0;
    int failures = 0;

    systolic_array_param #(.N(N), .DW(DW), .AW(40), .KW(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .busy(busy), .done(done)
    );

    systolic_array_param #(.N(N), .DW(DW), .AW(32), .KW(8)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready32), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid32), .out_ready(out_ready), .out_row(out_row32),
        .out_last(out_last32), .busy(busy32), .done(done32)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack_a(input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = a_m[i][k][15:0];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] pack_b(input int k);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = b_m[k][j][15:0];
        return v;
    endfunction

    function automatic logic [N*40-1:0] exp_row40(input int r);
        logic [N*40-1:0] v;
        for (int j = 0; j < N; j++) v[j*40 +: 40] = c_exp[r][j][39:0];
        return v;
    endfunction

    function automatic logic [N*32-1:0] exp_row32(input int r);
        logic [N*32-1:0] v;
        for (int j = 0; j < N; j++) v[j*32 +: 32] = c_exp[r][j][31:0];
        return v;
    endfunction

    task automatic load_test1();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) a_m[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < N; j++) b_m[k][j] = 4 * k + j + 1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c_exp[i][j] = 4 * i + j + 1;
    endtask

    task automatic fill(input longint a_val, input longint b_val, input longint c_val);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) begin
                a_m[i][k] = a_val;
                b_m[k][i] = b_val;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c_exp[i][j] = c_val;
    endtask

    // Runs one complete multiply from start to done; entered and left on a falling edge.
    task automatic run_op(input int k, input bit bubbles, input int stall, input bit poke,
                          input string name);
        time t_ref, t_first;
        int  idx, phase, n;
        bit  hs;
        @(negedge clk);
        check($sformatf("%s idle_busy", name), busy, 1'b0);
        start = 1'b1;
        k_len = k[7:0];
        @(posedge clk);
        t_ref = $time;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s busy_after_start", name), {busy, busy32}, 2'b11);
        check($sformatf("%s in_ready_after_start", name), {in_ready, in_ready32},
              (k != 0) ? 2'b11 : 2'b00);

        idx = 0;
        phase = 0;
        while (idx < k && phase < 4 * k + 8) begin
            in_valid = bubbles ? (phase % 2 == 0) : 1'b1;
            if (in_valid) begin
                a_col = pack_a(idx);
                b_row = pack_b(idx);
            end else begin
                a_col = {N{16'h1111}};
                b_row = {N{16'h2222}};
            end
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) begin
                idx++;
                t_ref = $time;
            end
            @(negedge clk);
            phase++;
        end
        in_valid = 1'b0;
        check($sformatf("%s beats_accepted", name), idx, k);
        if (k != 0)
            check($sformatf("%s in_ready_after_last", name), in_ready, 1'b0);

        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s out_valid_seen", name), out_valid, 1'b1);
        if (!out_valid) return;
        t_first = $time - 5;
        check($sformatf("%s first_valid_latency", name), int'((t_first - t_ref) / 10),
              (k == 0) ? 0 : 2 * N);

        for (int r = 0; r < N; r++) begin
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                if (poke) begin
                    start = 1'b1;
                    k_len = 8'd3;
                end
                check($sformatf("%s r%0d stall%0d row", name, r, s), out_row, exp_row40(r));
                check($sformatf("%s r%0d stall%0d last", name, r, s), out_last, r == N - 1);
                check($sformatf("%s r%0d stall%0d valid", name, r, s), out_valid, 1'b1);
                @(negedge clk);
            end
            out_ready = 1'b1;
            start = 1'b0;
            check($sformatf("%s r%0d valid", name, r), {out_valid, out_valid32}, 2'b11);
            check($sformatf("%s r%0d row40", name, r), out_row, exp_row40(r));
            check($sformatf("%s r%0d row32", name, r), out_row32, exp_row32(r));
            check($sformatf("%s r%0d last", name, r), {out_last, out_last32},
                  (r == N - 1) ? 2'b11 : 2'b00);
            check($sformatf("%s r%0d done_low", name, r), done, 1'b0);
            @(negedge clk);
        end
        check($sformatf("%s done_pulse", name), {done, done32}, 2'b11);
        check($sformatf("%s busy_fall", name), {busy, busy32}, 2'b00);
        check($sformatf("%s valid_fall", name), out_valid, 1'b0);
        @(negedge clk);
        check($sformatf("%s done_one_cycle", name), done, 1'b0);
        if (poke)
            check($sformatf("%s poke_ignored", name), busy, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        k_len = '0;
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;
        out_ready = 1'b1;

        #1 rst = 1'b1;
        @(negedge clk);
        check("reset in_ready", {in_ready, in_ready32}, 2'b00);
        check("reset out_valid", {out_valid, out_valid32}, 2'b00);
        check("reset out_row", out_row, '0);
        check("reset out_last", out_last, 1'b0);
        check("reset busy", {busy, busy32}, 2'b00);
        check("reset done", {done, done32}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        load_test1();
        run_op(4, 1'b0, 0, 1'b0, "ident");

        fill(-3, 7, -105);
        run_op(5, 1'b0, 0, 1'b0, "signed");

        load_test1();
        run_op(4, 1'b1, 3, 1'b0, "bubble");

        fill(0, 0, 0);
        run_op(0, 1'b0, 2, 1'b1, "kzero");

        fill(32767, 32767, 64'h1_FFF8_0008);
        run_op(8, 1'b0, 0, 1'b0, "wrap");

        // Abort a load after two beats of junk, then rerun the identity case cleanly.
        fill(5, 9, 0);
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            a_col = pack_a(b);
            b_row = pack_b(b);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("abort in_ready_before_rst", in_ready, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("abort in_ready", in_ready, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort out_valid", out_valid, 1'b0);
        check("abort out_row", out_row, '0);
        check("abort out_last", out_last, 1'b0);
        check("abort done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort no_done", done, 1'b0);

        load_test1();
        run_op(4, 1'b0, 0, 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
